// File: rtl/axi_sram_slave.sv
// AXI4 slave backed by an internal word array; one read or write burst at a time.
// Supports FIXED/INCR/WRAP bursts, byte strobes and out-of-range SLVERR reporting.
module axi_sram_slave #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16384,
  parameter int ID_W   = 8
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ID_W-1:0]     ARID,
  input  logic [31:0]         ARADDR,
  input  logic [7:0]          ARLEN,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY,
  input  logic [ID_W-1:0]     AWID,
  input  logic [31:0]         AWADDR,
  input  logic [7:0]          AWLEN,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, WRESP = 2'd3} state_t;

  // Illegal WRAP lengths and the reserved burst code fall through to INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [1:0] burst);
    logic [31:0] win_mask;
    win_mask = (({24'd0, len} + 32'd1) << OFF) - 32'd1;
    if (burst == BURST_FIXED) begin
      next_addr = addr;
    end else if ((burst == BURST_WRAP) &&
                 ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15))) begin
      next_addr = (addr & ~win_mask) | ((addr + 32'(STRB_W)) & win_mask);
    end else begin
      next_addr = addr + 32'(STRB_W);
    end
  endfunction

  state_t              state_q;
  logic [31:0]         addr_q;
  logic [31:0]         addr_d;
  logic [7:0]          len_q;
  logic [7:0]          beat_q;
  logic [1:0]          burst_q;
  logic                err_q;
  logic                last_rd_q;
  logic [ID_W-1:0]     rid_q;
  logic [ID_W-1:0]     bid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          rresp_q;
  logic [1:0]          bresp_q;
  logic                rlast_q;
  logic                rvalid_q;
  logic                wready_q;
  logic                bvalid_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                idle_s;
  logic                conflict_s;
  logic                ar_ready_s;
  logic                aw_ready_s;
  logic                ar_hs_s;
  logic                aw_hs_s;
  logic [31:0]         rd_addr_s;
  logic [31:0]         rd_idx_s;
  logic                rd_oob_s;
  logic [DATA_W-1:0]   rd_data_s;
  logic [31:0]         wr_idx_s;
  logic                wr_oob_s;
  logic                w_final_s;
  logic                w_beat_err_s;
  logic                we_s;

  // Both requests pending: only the side opposite to the last grant sees READY.
  assign idle_s     = (state_q == IDLE);
  assign conflict_s = ARVALID && AWVALID;
  assign ar_ready_s = idle_s && !(conflict_s && last_rd_q);
  assign aw_ready_s = idle_s && !(conflict_s && !last_rd_q);
  assign ar_hs_s    = ARVALID && ar_ready_s;
  assign aw_hs_s    = AWVALID && aw_ready_s && !ar_hs_s;

  assign addr_d    = next_addr(addr_q, len_q, burst_q);
  assign rd_addr_s = idle_s ? ARADDR : addr_d;
  assign rd_idx_s  = rd_addr_s >> OFF;
  assign rd_oob_s  = (rd_idx_s >= 32'(DEPTH));
  assign rd_data_s = mem[rd_idx_s[AW-1:0]];

  assign wr_idx_s     = addr_q >> OFF;
  assign wr_oob_s     = (wr_idx_s >= 32'(DEPTH));
  assign w_final_s    = (beat_q == len_q);
  assign w_beat_err_s = wr_oob_s || (WLAST != w_final_s);
  assign we_s         = (state_q == WR) && WVALID && !wr_oob_s;

  assign ARREADY = ar_ready_s;
  assign AWREADY = aw_ready_s;
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;
  assign RVALID  = rvalid_q;
  assign WREADY  = wready_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;
  assign BVALID  = bvalid_q;

  // Burst controller: arbitration, beat sequencing and all registered channel outputs.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      addr_q    <= 32'd0;
      len_q     <= 8'd0;
      beat_q    <= 8'd0;
      burst_q   <= 2'b00;
      err_q     <= 1'b0;
      last_rd_q <= 1'b0;
      rid_q     <= '0;
      bid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      bresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ar_hs_s) begin
            state_q   <= RD;
            addr_q    <= ARADDR;
            len_q     <= ARLEN;
            burst_q   <= ARBURST;
            beat_q    <= 8'd0;
            rid_q     <= ARID;
            rdata_q   <= rd_oob_s ? '0 : rd_data_s;
            rresp_q   <= rd_oob_s ? RESP_SLVERR : RESP_OKAY;
            rlast_q   <= (ARLEN == 8'd0);
            rvalid_q  <= 1'b1;
            last_rd_q <= 1'b1;
          end else if (aw_hs_s) begin
            state_q   <= WR;
            addr_q    <= AWADDR;
            len_q     <= AWLEN;
            burst_q   <= AWBURST;
            beat_q    <= 8'd0;
            bid_q     <= AWID;
            err_q     <= 1'b0;
            wready_q  <= 1'b1;
            last_rd_q <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        RD: begin
          if (RREADY) begin
            if (rlast_q) begin
              state_q  <= IDLE;
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
            end else begin
              addr_q  <= addr_d;
              beat_q  <= beat_q + 8'd1;
              rdata_q <= rd_oob_s ? '0 : rd_data_s;
              rresp_q <= rd_oob_s ? RESP_SLVERR : RESP_OKAY;
              rlast_q <= ((beat_q + 8'd1) == len_q);
            end
          end else begin
            state_q <= RD;
          end
        end
        WR: begin
          if (WVALID) begin
            addr_q <= addr_d;
            beat_q <= beat_q + 8'd1;
            if (w_final_s) begin
              state_q  <= WRESP;
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (err_q || w_beat_err_s) ? RESP_SLVERR : RESP_OKAY;
            end else begin
              err_q <= err_q || w_beat_err_s;
            end
          end else begin
            state_q <= WR;
          end
        end
        WRESP: begin
          if (BREADY) begin
            state_q  <= IDLE;
            bvalid_q <= 1'b0;
          end else begin
            state_q <= WRESP;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Byte-lane array write; contents deliberately survive reset.
  always_ff @(posedge ACLK) begin
    if (we_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) begin
          mem[wr_idx_s[AW-1:0]][8*b +: 8] <= WDATA[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: a queue-based reference model is checked on every
// negative clock edge, and hand-computed literals pin the model's key results.
module tb_axi_sram_slave;
  localparam int DEPTH = 1024;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [7:0]  ARID = 8'd0;
  logic [31:0] ARADDR = 32'd0;
  logic [7:0]  ARLEN = 8'd0;
  logic [1:0]  ARBURST = 2'b01;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic [7:0]  AWID = 8'd0;
  logic [31:0] AWADDR = 32'd0;
  logic [7:0]  AWLEN = 8'd0;
  logic [1:0]  AWBURST = 2'b01;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = 32'd0;
  logic [3:0]  WSTRB = 4'd0;
  logic        WLAST = 1'b0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;

  axi_sram_slave #(.DATA_W(32), .DEPTH(DEPTH), .ID_W(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [7:0]  id;
  } rbeat_t;
  typedef struct {
    logic [1:0] resp;
    logic [7:0] id;
  } bresp_t;

  rbeat_t      exp_r[$];
  bresp_t      exp_b[$];
  logic [31:0] model_mem [int];
  logic [31:0] got_data [16];
  logic [1:0]  got_resp [16];
  logic [1:0]  got_bresp;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Address of beat i, computed arithmetically from the burst rules.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [1:0] burst, input int i);
    logic [31:0] win;
    if (burst == 2'b00) return a;
    if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      win = (32'(len) + 32'd1) * 32'd4;
      return (a / win) * win + (((a % win) + 32'(i) * 32'd4) % win);
    end
    return a + 32'(i) * 32'd4;
  endfunction

  task automatic model_read(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                            input logic [7:0] id);
    rbeat_t      e;
    logic [31:0] ba;
    for (int i = 0; i <= int'(len); i++) begin
      ba = beat_addr(a, len, burst, i);
      if ((ba >> 2) >= 32'(DEPTH)) begin
        e.data = 32'd0;
        e.resp = 2'b10;
      end else begin
        e.data = model_mem[int'(ba >> 2)];
        e.resp = 2'b00;
      end
      e.last = (i == int'(len));
      e.id   = id;
      exp_r.push_back(e);
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                             input logic [7:0] id, input logic [31:0] d0, input logic [31:0] step,
                             input logic [3:0] strb, input int bad);
    bresp_t      e;
    logic [31:0] ba;
    logic [31:0] d;
    logic [31:0] w;
    logic        lastv;
    e.resp = 2'b00;
    e.id   = id;
    for (int i = 0; i <= int'(len); i++) begin
      ba    = beat_addr(a, len, burst, i);
      d     = d0 + 32'(i) * step;
      lastv = (i == int'(len)) ^ (i == bad);
      if (lastv != (i == int'(len))) e.resp = 2'b10;
      if ((ba >> 2) >= 32'(DEPTH)) begin
        e.resp = 2'b10;
      end else begin
        w = model_mem.exists(int'(ba >> 2)) ? model_mem[int'(ba >> 2)] : 32'd0;
        for (int b = 0; b < 4; b++)
          if (strb[b]) w[8*b +: 8] = d[8*b +: 8];
        model_mem[int'(ba >> 2)] = w;
      end
    end
    exp_b.push_back(e);
  endtask

  // Scoreboard: every valid R/B beat must match the head of the model queue.
  always @(negedge ACLK) begin
    if (ARESETn) begin
      if (RVALID) begin
        if (exp_r.size() == 0) begin
          chk("r_unexpected", 32'(RVALID), 32'd0);
        end else begin
          chk("rdata", RDATA, exp_r[0].data);
          chk("rresp", 32'(RRESP), 32'(exp_r[0].resp));
          chk("rlast", 32'(RLAST), 32'(exp_r[0].last));
          chk("rid", 32'(RID), 32'(exp_r[0].id));
          if (RREADY) exp_r.delete(0);
        end
      end
      if (BVALID) begin
        if (exp_b.size() == 0) begin
          chk("b_unexpected", 32'(BVALID), 32'd0);
        end else begin
          chk("bresp", 32'(BRESP), 32'(exp_b[0].resp));
          chk("bid", 32'(BID), 32'(exp_b[0].id));
          if (BREADY) exp_b.delete(0);
        end
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_arready"}, 32'(ARREADY), 32'd1);
    chk({tag, "_awready"}, 32'(AWREADY), 32'd1);
    chk({tag, "_rvalid"}, 32'(RVALID), 32'd0);
    chk({tag, "_wready"}, 32'(WREADY), 32'd0);
    chk({tag, "_bvalid"}, 32'(BVALID), 32'd0);
    chk({tag, "_rlast"}, 32'(RLAST), 32'd0);
    chk({tag, "_rdata"}, RDATA, 32'd0);
    chk({tag, "_rid"}, 32'(RID), 32'd0);
    chk({tag, "_bid"}, 32'(BID), 32'd0);
    chk({tag, "_rresp"}, 32'(RRESP), 32'd0);
    chk({tag, "_bresp"}, 32'(BRESP), 32'd0);
  endtask

  task automatic r_phase(input logic [7:0] len, input int toggle);
    int          n = 0;
    int          cyc = 0;
    logic        stalled = 1'b0;
    logic [31:0] prev = 32'd0;
    RREADY = (toggle == 0);
    while (n <= int'(len) && cyc < 100) begin
      @(negedge ACLK);
      if (cyc == 0) chk("r_latency", 32'(RVALID), 32'd1);
      else if (toggle == 0) chk("r_no_bubble", 32'(RVALID), 32'd1);
      if (stalled) chk("r_stable", RDATA, prev);
      if (RVALID && RREADY) begin
        got_data[n] = RDATA;
        got_resp[n] = RRESP;
        n++;
        stalled = 1'b0;
      end else begin
        stalled = RVALID;
        prev    = RDATA;
      end
      cyc++;
      @(posedge ACLK); #1;
      if (toggle != 0) RREADY = ~RREADY;
    end
    RREADY = 1'b0;
    if (n <= int'(len)) chk("r_timeout", 32'(n), 32'(len) + 32'd1);
  endtask

  task automatic w_phase(input logic [7:0] len, input logic [31:0] d0, input logic [31:0] step,
                         input logic [3:0] strb, input int bad);
    int t;
    for (int i = 0; i <= int'(len); i++) begin
      WVALID = 1'b1;
      WDATA  = d0 + 32'(i) * step;
      WSTRB  = strb;
      WLAST  = (i == int'(len)) ^ (i == bad);
      t = 0;
      do begin @(negedge ACLK); t++; end while (!WREADY && t < 50);
      if (!WREADY) chk("w_timeout", 32'(WREADY), 32'd1);
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
  endtask

  task automatic b_phase();
    int t = 0;
    BREADY = 1'b1;
    do begin @(negedge ACLK); t++; end while (!BVALID && t < 50);
    if (!BVALID) chk("b_timeout", 32'(BVALID), 32'd1);
    got_bresp = BRESP;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
  endtask

  task automatic rd_burst(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                          input logic [7:0] id, input int toggle);
    int t = 0;
    model_read(a, len, burst, id);
    ARADDR = a; ARLEN = len; ARBURST = burst; ARID = id; ARVALID = 1'b1;
    do begin @(negedge ACLK); t++; end while (!ARREADY && t < 50);
    if (!ARREADY) chk("ar_timeout", 32'(ARREADY), 32'd1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    r_phase(len, toggle);
  endtask

  task automatic wr_burst(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                          input logic [7:0] id, input logic [31:0] d0, input logic [31:0] step,
                          input logic [3:0] strb, input int bad);
    int t = 0;
    model_write(a, len, burst, id, d0, step, strb, bad);
    AWADDR = a; AWLEN = len; AWBURST = burst; AWID = id; AWVALID = 1'b1;
    do begin @(negedge ACLK); t++; end while (!AWREADY && t < 50);
    if (!AWREADY) chk("aw_timeout", 32'(AWREADY), 32'd1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    w_phase(len, d0, step, strb, bad);
    b_phase();
  endtask

  initial begin
    int t;
    chk("model_wrap_b1", beat_addr(32'h108, 8'd3, 2'b10, 1), 32'h10C);
    chk("model_wrap_b2", beat_addr(32'h108, 8'd3, 2'b10, 2), 32'h100);
    chk("model_wrap_b3", beat_addr(32'h108, 8'd3, 2'b10, 3), 32'h104);

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    reset_checks("rst");
    @(posedge ACLK); #1;
    ARESETn = 1'b1;

    // INCR write then read back
    wr_burst(32'h100, 8'd3, 2'b01, 8'h05, 32'h11, 32'h11, 4'hF, -1);
    chk("incr_w_bresp", 32'(got_bresp), 32'd0);

    // Conflict 1: read wins
    model_read(32'h100, 8'd3, 2'b01, 8'h03);
    ARADDR = 32'h100; ARLEN = 8'd3; ARBURST = 2'b01; ARID = 8'h03;
    AWADDR = 32'h0; AWLEN = 8'd0; AWBURST = 2'b01; AWID = 8'h07;
    ARVALID = 1'b1; AWVALID = 1'b1;
    @(negedge ACLK);
    chk("conf1_arready", 32'(ARREADY), 32'd1);
    chk("conf1_awready", 32'(AWREADY), 32'd0);
    @(posedge ACLK); #1;
    ARVALID = 1'b0; AWVALID = 1'b0;
    r_phase(8'd3, 0);
    chk("incr_r0", got_data[0], 32'h11);
    chk("incr_r1", got_data[1], 32'h22);
    chk("incr_r2", got_data[2], 32'h33);
    chk("incr_r3", got_data[3], 32'h44);

    // Conflict 2: write wins
    model_write(32'h0, 8'd0, 2'b01, 8'h07, 32'hCAFE0000, 32'd0, 4'hF, -1);
    ARVALID = 1'b1; AWVALID = 1'b1;
    @(negedge ACLK);
    chk("conf2_arready", 32'(ARREADY), 32'd0);
    chk("conf2_awready", 32'(AWREADY), 32'd1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0; AWVALID = 1'b0;
    w_phase(8'd0, 32'hCAFE0000, 32'd0, 4'hF, -1);
    b_phase();

    // WRAP and FIXED reads
    rd_burst(32'h108, 8'd3, 2'b10, 8'h09, 0);
    chk("wrap_r0", got_data[0], 32'h33);
    chk("wrap_r1", got_data[1], 32'h44);
    chk("wrap_r2", got_data[2], 32'h11);
    chk("wrap_r3", got_data[3], 32'h22);
    rd_burst(32'h104, 8'd2, 2'b00, 8'h0A, 0);
    chk("fixed_r2", got_data[2], 32'h22);

    // Strobes, then 8-beat read with RREADY toggling
    wr_burst(32'h200, 8'd7, 2'b01, 8'h11, 32'h1000, 32'h101, 4'hF, -1);
    wr_burst(32'h204, 8'd0, 2'b01, 8'h12, 32'hFFFFFFFF, 32'd0, 4'b0101, -1);
    wr_burst(32'h208, 8'd0, 2'b01, 8'h13, 32'hDEADBEEF, 32'd0, 4'b0000, -1);
    rd_burst(32'h200, 8'd7, 2'b01, 8'h14, 1);
    chk("strb_partial", got_data[1], 32'h00FF11FF);
    chk("strb_zero", got_data[2], 32'h00001202);
    chk("toggle_r7", got_data[7], 32'h00001707);

    // Out-of-range write and read
    wr_burst(32'(DEPTH) * 32'd4, 8'd0, 2'b01, 8'h20, 32'h55555555, 32'd0, 4'hF, -1);
    chk("oob_bresp", 32'(got_bresp), 32'd2);
    rd_burst(32'h0, 8'd0, 2'b01, 8'h21, 0);
    chk("oob_unchanged", got_data[0], 32'hCAFE0000);
    rd_burst(32'(DEPTH) * 32'd4, 8'd0, 2'b01, 8'h22, 0);
    chk("oob_rdata", got_data[0], 32'd0);
    chk("oob_rresp", 32'(got_resp[0]), 32'd2);

    // Early WLAST
    wr_burst(32'h300, 8'd1, 2'b01, 8'h30, 32'h77, 32'h1, 4'hF, 0);
    chk("wlast_bresp", 32'(got_bresp), 32'd2);

    // Reset during beat 2 of a 4-beat write
    AWADDR = 32'h100; AWLEN = 8'd3; AWBURST = 2'b01; AWID = 8'h44; AWVALID = 1'b1;
    t = 0;
    do begin @(negedge ACLK); t++; end while (!AWREADY && t < 50);
    if (!AWREADY) chk("aw_timeout", 32'(AWREADY), 32'd1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    WVALID = 1'b1; WDATA = 32'hA0; WSTRB = 4'hF; WLAST = 1'b0;
    @(negedge ACLK);
    chk("rst_w0_wready", 32'(WREADY), 32'd1);
    @(posedge ACLK); #1;
    model_mem[32'h100 >> 2] = 32'hA0;
    WDATA = 32'hB0;
    #2 ARESETn = 1'b0;
    @(negedge ACLK);
    reset_checks("midrst");
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    repeat (5) begin
      @(negedge ACLK);
      chk("midrst_no_b", 32'(BVALID), 32'd0);
      chk("midrst_idle", 32'(ARREADY), 32'd1);
    end
    @(posedge ACLK); #1;
    rd_burst(32'h100, 8'd3, 2'b01, 8'h55, 0);
    chk("post_rst_r0", got_data[0], 32'hA0);
    chk("post_rst_r1", got_data[1], 32'h22);
    chk("post_rst_r3", got_data[3], 32'h44);

    repeat (3) @(posedge ACLK);
    chk("r_queue_empty", 32'(exp_r.size()), 32'd0);
    chk("b_queue_empty", 32'(exp_b.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameters SHALL be as follows:
- DATA_W, default 32: data width in bits; one of 32, 64 or 128.
- DEPTH, default 16384: number of DATA_W-bit words in the internal array.
- ID_W, default 8: width of the AXI ID fields.
REQ-002 Ports SHALL be, clock and reset first, with ARESETn asynchronous, active-low, and all logic clocked on ACLK:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- ARID  in  ID_W  read ID
- ARADDR  in  32  read byte address
- ARLEN  in  8  read beats minus one
- ARBURST  in  2  read burst type (00 FIXED, 01 INCR, 10 WRAP)
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- RID  out  ID_W  read ID
- RDATA  out  DATA_W  read data
- RRESP  out  2  read response (00 OKAY, 10 SLVERR)
- RLAST  out  1  final read beat
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- AWID  in  ID_W  write ID
- AWADDR  in  32  write byte address
- AWLEN  in  8  write beats minus one
- AWBURST  in  2  write burst type
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WDATA  in  DATA_W  write data
- WSTRB  in  DATA_W/8  byte enables; bit i enables byte i
- WLAST  in  1  final write beat
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BID  out  ID_W  write response ID
- BRESP  out  2  write response
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready

Function
REQ-003 The FSM SHALL have the states IDLE, RD, WR and WRESP; ARREADY and AWREADY are asserted only in IDLE; only one burst is in flight at a time.
REQ-004 Arbitration in IDLE SHALL work as follows:
- If only one of ARVALID or AWVALID is high, that request is accepted.
- If both are high, the request opposite to the last grant is accepted, and only the granted READY is asserted.
- The last-grant register resets to "write", so read wins the first conflict.
REQ-005 Addressing SHALL use word index = ADDR >> log2(DATA_W/8); the low address bits are ignored (aligned transfers only).
REQ-006 Burst address update SHALL be:
- FIXED: the address stays constant for all beats.
- INCR: the address advances by DATA_W/8 bytes per beat.
- WRAP: valid only when LEN is 1, 3, 7 or 15; the address wraps within an aligned (LEN+1)*DATA_W/8-byte window.
- WRAP with any other LEN, or burst type 11, is treated as INCR.
REQ-007 Read path SHALL behave as follows:
- RVALID is asserted on the cycle after the AR handshake.
- Each subsequent beat is presented on the cycle after the previous R handshake, with no bubble when RREADY is held high.
- RID is the captured ARID; RLAST is high on beat ARLEN.
- RDATA, RRESP, RLAST and RID are stable while RVALID=1 and RREADY=0.
REQ-008 Write path SHALL behave as follows:
- WREADY=1 throughout WR.
- Each W handshake writes the bytes selected by WSTRB at the current address, then the address advances.
- WSTRB=0 writes nothing.
REQ-009 Write burst termination SHALL be:
- WR ends after AWLEN+1 handshakes, regardless of WLAST.
- BRESP=SLVERR if WLAST is low on the final beat or high on an earlier beat; otherwise OKAY unless REQ-010 applies.
REQ-010 A beat whose word index is >= DEPTH SHALL be out of range:
- On a write, the array is not modified.
- On a read, RDATA=0 and RRESP=SLVERR for that beat only.
- On a write burst, BRESP=SLVERR if any beat was out of range.
REQ-011 WRESP SHALL assert BVALID with BID = captured AWID, hold it until BREADY, then return to IDLE; a request arriving on that same cycle is accepted no earlier than the following cycle.
REQ-012 RD SHALL return to IDLE on the handshake of the RLAST beat.
REQ-013 Reads SHALL return the most recently completed write to the same word.

Reset
REQ-014 While ARESETn=0, the FSM SHALL be in IDLE with RVALID, WREADY, BVALID and RLAST at 0, RDATA, RID and BID at 0, RRESP and BRESP at OKAY, and ARREADY=AWREADY=1.
REQ-015 Reset mid-burst SHALL abandon the burst with no further R or B beats; array contents are not reset.

Verification
REQ-016 The bench SHALL cover:
- INCR write AWADDR=0x100, AWLEN=3, data 0x11..0x44, WSTRB=all-ones -> BRESP=OKAY; INCR read of the same range returns 0x11,0x22,0x33,0x44 with RLAST on beat 4.
- WRAP read ARADDR=0x108, ARLEN=3, DATA_W=32 -> beat addresses 0x108, 0x10C, 0x100, 0x104.
- ARVALID and AWVALID raised together, twice -> read granted first, write granted second.
- RREADY toggled 0/1 during an 8-beat read -> RDATA stable while stalled, all 8 beats in order.
- Write to word index DEPTH -> BRESP=SLVERR and the array is unchanged; read of the same address -> RDATA=0, RRESP=SLVERR.
- ARESETn pulsed low during beat 2 of a 4-beat write -> BVALID never asserted, FSM in IDLE, and a subsequent read completes normally.
